// File: rtl/nm_aer_pkg.sv
// rtl/nm_aer_pkg.sv - shared AER word layout, default sizes and TX FSM encodings
package nm_aer_pkg;

    localparam int NM_N_NEURONS  = 4;
    localparam int NM_ADDR_W     = 2;
    localparam int NM_TS_W       = 6;
    localparam int NM_TS_DIV     = 16;
    localparam int NM_FIFO_DEPTH = 4;

    // AER word is {addr, ts}: timestamp in the low bits, address above it
    localparam int AER_TS_LSB   = 0;
    localparam int AER_TS_MSB   = NM_TS_W - 1;
    localparam int AER_ADDR_LSB = NM_TS_W;
    localparam int AER_ADDR_MSB = NM_TS_W + NM_ADDR_W - 1;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_REQ  = 2'd1,
        TX_REL  = 2'd2
    } tx_state_e;

endpackage

// File: rtl/aer_fifo.sv
// rtl/aer_fifo.sv - synchronous event FIFO between arbiter and TX handshake
// Ports: clk, reset_n (async, active-low); push/wdata write side (ignored when full,
// even if a pop happens in the same cycle); pop/rdata read side (rdata is the head,
// valid when !empty); full, empty, level (occupancy 0..DEPTH).
module aer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            // DEPTH is a power of two, so the pointer wraps naturally
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/spike_aer_tx.sv
// rtl/spike_aer_tx.sv - AER transmitter: spike edge capture, round-robin buffering, 4-phase req/ack output
// Ports: clk, reset_n (async, active-low); ena gates capture and timestamping;
// spike_in per-neuron levels; aer_ack async receiver acknowledge; clr_ovf clears overflow;
// aer_req/aer_data registered handshake outputs ({addr, ts}); overflow sticky loss flag;
// fifo_level buffered event count.
module spike_aer_tx
    import nm_aer_pkg::*;
#(
    parameter int N_NEURONS  = NM_N_NEURONS,
    parameter int ADDR_W     = NM_ADDR_W,
    parameter int TS_W       = NM_TS_W,
    parameter int TS_DIV     = NM_TS_DIV,
    parameter int FIFO_DEPTH = NM_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          ena,
    input  logic [N_NEURONS-1:0]          spike_in,
    input  logic                          aer_ack,
    input  logic                          clr_ovf,
    output logic                          aer_req,
    output logic [ADDR_W+TS_W-1:0]        aer_data,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AER_W = ADDR_W + TS_W;
    localparam int PS_W  = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;

    logic [N_NEURONS-1:0] spike_q, spike_d;
    logic [N_NEURONS-1:0] pend_q, pend_d;
    logic [TS_W-1:0]      ts_lat_q [N_NEURONS];
    logic [TS_W-1:0]      ts_lat_d [N_NEURONS];
    logic [ADDR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [TS_W-1:0]      ts_q, ts_d;
    logic [PS_W-1:0]      ps_q, ps_d;
    logic                 overflow_q, overflow_d;
    logic                 ack_meta_q, ack_meta_d;
    logic                 ack_s_q, ack_s_d;
    tx_state_e            state_q, state_d;
    logic                 aer_req_q, aer_req_d;
    logic [AER_W-1:0]     aer_data_q, aer_data_d;

    logic [N_NEURONS-1:0] ev;
    logic                 grant_vld;
    logic [ADDR_W-1:0]    grant_idx;
    logic                 lost;
    logic                 fifo_full, fifo_empty, fifo_pop;
    logic [AER_W-1:0]     fifo_rdata;
    int                   idx;

    assign ev         = spike_in & ~spike_q & {N_NEURONS{ena}};
    assign aer_req    = aer_req_q;
    assign aer_data   = aer_data_q;
    assign overflow   = overflow_q;

    aer_fifo #(
        .WIDTH (AER_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (grant_vld),
        .wdata   ({grant_idx, ts_lat_q[grant_idx]}),
        .pop     (fifo_pop),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Round-robin search starting at rr_ptr; no grant while the FIFO is full so
    // the event simply waits in pend.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        rr_ptr_d  = rr_ptr_q;
        for (int k = 0; k < N_NEURONS; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_NEURONS;
            if (!grant_vld && !fifo_full && pend_q[idx]) begin
                grant_vld = 1'b1;
                grant_idx = ADDR_W'(idx);
            end
        end
        if (grant_vld) begin
            rr_ptr_d = ADDR_W'((int'(grant_idx) + 1) % N_NEURONS);
        end
    end

    // A new edge on a neuron whose previous event is still waiting is dropped;
    // an edge in the same cycle as that neuron's grant re-arms it with the new ts.
    always_comb begin
        spike_d  = spike_in;
        pend_d   = pend_q;
        ts_lat_d = ts_lat_q;
        lost     = 1'b0;
        for (int i = 0; i < N_NEURONS; i++) begin
            if (grant_vld && (grant_idx == ADDR_W'(i))) begin
                pend_d[i] = ev[i];
                if (ev[i]) begin
                    ts_lat_d[i] = ts_q;
                end
            end else if (ev[i]) begin
                if (pend_q[i]) begin
                    lost = 1'b1;
                end else begin
                    pend_d[i]   = 1'b1;
                    ts_lat_d[i] = ts_q;
                end
            end
        end
        // set wins over a simultaneous clear
        overflow_d = lost | (overflow_q & ~clr_ovf);
    end

    always_comb begin
        ps_d = ps_q;
        ts_d = ts_q;
        if (ena) begin
            if (ps_q == PS_W'(TS_DIV - 1)) begin
                ps_d = '0;
                ts_d = ts_q + TS_W'(1);
            end else begin
                ps_d = ps_q + PS_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spike_q    <= '0;
            pend_q     <= '0;
            ts_lat_q   <= '{default: '0};
            rr_ptr_q   <= '0;
            ts_q       <= '0;
            ps_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            spike_q    <= spike_d;
            pend_q     <= pend_d;
            ts_lat_q   <= ts_lat_d;
            rr_ptr_q   <= rr_ptr_d;
            ts_q       <= ts_d;
            ps_q       <= ps_d;
            overflow_q <= overflow_d;
        end
    end

    // aer_ack comes from another clock domain; only ack_s_q is used by the FSM
    assign ack_meta_d = aer_ack;
    assign ack_s_d    = ack_meta_q;

    // aer_req is registered, so it is computed together with the next state
    always_comb begin
        state_d    = state_q;
        aer_req_d  = aer_req_q;
        aer_data_d = aer_data_q;
        fifo_pop   = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    aer_data_d = fifo_rdata;
                    aer_req_d  = 1'b1;
                    state_d    = TX_REQ;
                end
            end
            TX_REQ: begin
                if (ack_s_q) begin
                    aer_req_d = 1'b0;
                    state_d   = TX_REL;
                end
            end
            TX_REL: begin
                if (!ack_s_q) begin
                    state_d = TX_IDLE;
                end
            end
            default: begin
                aer_req_d = 1'b0;
                state_d   = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
            state_q    <= TX_IDLE;
            aer_req_q  <= 1'b0;
            aer_data_q <= '0;
        end else begin
            ack_meta_q <= ack_meta_d;
            ack_s_q    <= ack_s_d;
            state_q    <= state_d;
            aer_req_q  <= aer_req_d;
            aer_data_q <= aer_data_d;
        end
    end

endmodule
